inst_queue: RTL and testbench

Dual-issue instruction queue between fetch and the launch stage. Fetch enqueues up to two instructions per cycle in program order. The queue holds them in a circular buffer and presents the two oldest entries, with their PC and next-PC, to launch. Launch reports how many it issued (0, 1 or 2) and the queue retires exactly that many from the head. A flush empties the queue on a redirect.

---
 rtl/inst_queue_pkg.sv | 27 ++
 rtl/inst_queue_ram.sv | 43 ++++
 rtl/inst_queue.sv | 139 +++++++++++++
 tb/tb_inst_queue.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_queue_pkg.sv
// rtl/inst_queue_pkg.sv - shared types for the instruction queue and launch stage
package inst_queue_pkg;

  localparam int XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] npc;
    logic [XLEN-1:0] inst;
  } iq_entry_t;

  // pop_cnt of 3 means 2; never retire more than the occupancy flags allow
  function automatic logic [1:0] deq_count(input logic [1:0] pop_cnt,
                                           input logic       has1,
                                           input logic       has2);
    logic [1:0] req;
    req = (pop_cnt == 2'd3) ? 2'd2 : pop_cnt;
    if (!has1) begin
      deq_count = 2'd0;
    end else if (!has2 && req == 2'd2) begin
      deq_count = 2'd1;
    end else begin
      deq_count = req;
    end
  endfunction

endpackage

// File: rtl/inst_queue_ram.sv
// rtl/inst_queue_ram.sv - DEPTH-entry register array, two write ports, two async read ports
module inst_queue_ram
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we1,
  input  logic [AW-1:0] waddr1,
  input  iq_entry_t     wdata1,
  input  logic          we2,
  input  logic [AW-1:0] waddr2,
  input  iq_entry_t     wdata2,
  input  logic [AW-1:0] raddr1,
  output iq_entry_t     rdata1,
  input  logic [AW-1:0] raddr2,
  output iq_entry_t     rdata2
);

  iq_entry_t mem_q [DEPTH];
  iq_entry_t mem_d [DEPTH];

  // the two write addresses are always distinct (tail and tail+1)
  always_comb begin
    mem_d = mem_q;
    if (we1) mem_d[waddr1] = wdata1;
    if (we2) mem_d[waddr2] = wdata2;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata1 = mem_q[raddr1];
  assign rdata2 = mem_q[raddr2];

endmodule

// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - dual-issue instruction queue between fetch and launch
// Optional occupancy statistics counters are built with INST_QUEUE_STAT_EN.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid1,
  input  logic            in_valid2,
  input  logic [XLEN-1:0] in_pc1,
  input  logic [XLEN-1:0] in_npc1,
  input  logic [XLEN-1:0] in_inst1,
  input  logic [XLEN-1:0] in_pc2,
  input  logic [XLEN-1:0] in_npc2,
  input  logic [XLEN-1:0] in_inst2,
  output logic            in_ready,
  input  logic [1:0]      pop_cnt,
  output logic            out_valid1,
  output logic            out_valid2,
  output logic [XLEN-1:0] out_pc1,
  output logic [XLEN-1:0] out_npc1,
  output logic [XLEN-1:0] out_inst1,
  output logic [XLEN-1:0] out_pc2,
  output logic [XLEN-1:0] out_npc2,
  output logic [XLEN-1:0] out_inst2
`ifdef INST_QUEUE_STAT_EN
  ,
  output logic [31:0]     stat_full_cycles,
  output logic [31:0]     stat_empty_cycles
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [1:0]    enq_n;
  logic [1:0]    deq_n;
  logic          we1, we2;
  iq_entry_t     slot1, slot2, wdata1;
  iq_entry_t     rdata1, rdata2;

  assign in_ready   = (count_q <= READY_MAX);
  assign out_valid1 = (count_q >= CW'(1));
  assign out_valid2 = (count_q >= CW'(2));

  assign slot1 = '{pc: in_pc1, npc: in_npc1, inst: in_inst1};
  assign slot2 = '{pc: in_pc2, npc: in_npc2, inst: in_inst2};

  // valid slots are compacted: a lone slot 2 lands at tail
  always_comb begin
    enq_n  = in_ready ? ({1'b0, in_valid1} + {1'b0, in_valid2}) : 2'd0;
    deq_n  = deq_count(pop_cnt, out_valid1, out_valid2);
    we1    = !flush && in_ready && (in_valid1 || in_valid2);
    we2    = !flush && in_ready && in_valid1 && in_valid2;
    wdata1 = in_valid1 ? slot1 : slot2;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + AW'(deq_n);
      tail_d  = tail_q + AW'(enq_n);
      count_d = count_q + CW'(enq_n) - CW'(deq_n);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  inst_queue_ram #(.DEPTH(DEPTH)) u_ram (
    .clk    (clk),
    .rst    (rst),
    .we1    (we1),
    .waddr1 (tail_q),
    .wdata1 (wdata1),
    .we2    (we2),
    .waddr2 (tail_q + AW'(1)),
    .wdata2 (slot2),
    .raddr1 (head_q),
    .rdata1 (rdata1),
    .raddr2 (head_q + AW'(1)),
    .rdata2 (rdata2)
  );

  assign out_pc1   = rdata1.pc;
  assign out_npc1  = rdata1.npc;
  assign out_inst1 = rdata1.inst;
  assign out_pc2   = rdata2.pc;
  assign out_npc2  = rdata2.npc;
  assign out_inst2 = rdata2.inst;

`ifdef INST_QUEUE_STAT_EN
  logic [31:0] stat_full_q, stat_full_d;
  logic [31:0] stat_empty_q, stat_empty_d;

  // flush does not touch the statistics; they wrap naturally
  always_comb begin
    stat_full_d  = stat_full_q + {31'd0, ~in_ready};
    stat_empty_d = stat_empty_q + {31'd0, (count_q == '0)};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_full_q  <= '0;
      stat_empty_q <= '0;
    end else begin
      stat_full_q  <= stat_full_d;
      stat_empty_q <= stat_empty_d;
    end
  end

  assign stat_full_cycles  = stat_full_q;
  assign stat_empty_cycles = stat_empty_q;
`endif

endmodule

// File: tb/tb_inst_queue.sv
// tb/tb_inst_queue.sv - self-checking bench for inst_queue against a queue-based model
module tb_inst_queue;
  import inst_queue_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid1 = 1'b0, in_valid2 = 1'b0;
  logic [31:0] in_pc1 = '0, in_npc1 = '0, in_inst1 = '0;
  logic [31:0] in_pc2 = '0, in_npc2 = '0, in_inst2 = '0;
  logic [1:0]  pop_cnt = 2'd0;
  logic        in_ready;
  logic        out_valid1, out_valid2;
  logic [31:0] out_pc1, out_npc1, out_inst1;
  logic [31:0] out_pc2, out_npc2, out_inst2;
`ifdef INST_QUEUE_STAT_EN
  logic [31:0] stat_full_cycles, stat_empty_cycles;
`endif

  int compared = 0;
  int mismatched = 0;

  iq_entry_t   model_q[$];
  logic [31:0] m_full = '0;
  logic [31:0] m_empty = '0;

  always #5 clk = ~clk;

  inst_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid1  (in_valid1),
    .in_valid2  (in_valid2),
    .in_pc1     (in_pc1),
    .in_npc1    (in_npc1),
    .in_inst1   (in_inst1),
    .in_pc2     (in_pc2),
    .in_npc2    (in_npc2),
    .in_inst2   (in_inst2),
    .in_ready   (in_ready),
    .pop_cnt    (pop_cnt),
    .out_valid1 (out_valid1),
    .out_valid2 (out_valid2),
    .out_pc1    (out_pc1),
    .out_npc1   (out_npc1),
    .out_inst1  (out_inst1),
    .out_pc2    (out_pc2),
    .out_npc2   (out_npc2),
    .out_inst2  (out_inst2)
`ifdef INST_QUEUE_STAT_EN
    ,
    .stat_full_cycles  (stat_full_cycles),
    .stat_empty_cycles (stat_empty_cycles)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_model();
    int n;
    n = model_q.size();
    check("in_ready", 32'(in_ready), 32'((DEPTH - n) >= 2));
    check("out_valid1", 32'(out_valid1), 32'(n >= 1));
    check("out_valid2", 32'(out_valid2), 32'(n >= 2));
    if (n >= 1) begin
      check("out_pc1", out_pc1, model_q[0].pc);
      check("out_npc1", out_npc1, model_q[0].npc);
      check("out_inst1", out_inst1, model_q[0].inst);
    end
    if (n >= 2) begin
      check("out_pc2", out_pc2, model_q[1].pc);
      check("out_npc2", out_npc2, model_q[1].npc);
      check("out_inst2", out_inst2, model_q[1].inst);
    end
`ifdef INST_QUEUE_STAT_EN
    check("stat_full", stat_full_cycles, m_full);
    check("stat_empty", stat_empty_cycles, m_empty);
`endif
  endtask

  // Applies one clock edge of queue semantics to the model using the driven inputs
  task automatic model_step();
    int n, want, deq;
    bit rdy;
    n   = model_q.size();
    rdy = (DEPTH - n) >= 2;
    if (!rdy) m_full++;
    if (n == 0) m_empty++;
    if (flush) begin
      model_q.delete();
    end else begin
      want = (pop_cnt == 2'd3) ? 2 : int'(pop_cnt);
      deq  = (want < n) ? want : n;
      repeat (deq) void'(model_q.pop_front());
      if (rdy && in_valid1) model_q.push_back('{pc: in_pc1, npc: in_npc1, inst: in_inst1});
      if (rdy && in_valid2) model_q.push_back('{pc: in_pc2, npc: in_npc2, inst: in_inst2});
    end
  endtask

  task automatic tick();
    check_model();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic drive(input logic v1, input logic v2, input logic [31:0] pc1,
                       input logic [31:0] pc2, input logic [1:0] pop, input logic fl);
    in_valid1 = v1;
    in_valid2 = v2;
    in_pc1    = pc1;
    in_npc1   = pc1 + 32'd4;
    in_inst1  = ~pc1;
    in_pc2    = pc2;
    in_npc2   = pc2 + 32'd4;
    in_inst2  = pc2 ^ 32'h5a5a_0000;
    pop_cnt   = pop;
    flush     = fl;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0);
    rst = 1'b0;
    #1;
    model_q.delete();
    m_full  = '0;
    m_empty = '0;
    check("rst_valid1", 32'(out_valid1), 32'd0);
    check("rst_valid2", 32'(out_valid2), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_pc1", out_pc1, 32'd0);
    check("rst_inst2", out_inst2, 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #2;
    // basic pair enqueue, one-cycle latency
    do_reset();
    drive(1'b1, 1'b1, 32'h8000_0000, 32'h8000_0004, 2'd0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0);
    check("t1_valid1", 32'(out_valid1), 32'd1);
    check("t1_valid2", 32'(out_valid2), 32'd1);
    check("t1_pc1", out_pc1, 32'h8000_0000);
    check("t1_pc2", out_pc2, 32'h8000_0004);
    tick();

    // fill to full, held pair is not written, pop reopens
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 32'h1000 + 32'(i * 8), 32'h1004 + 32'(i * 8), 2'd0, 1'b0);
      tick();
      if (i == 2) check("t2_ready_at6", 32'(in_ready), 32'd1);
    end
    check("t2_ready_full", 32'(in_ready), 32'd0);
    drive(1'b1, 1'b1, 32'h2000, 32'h2004, 2'd1, 1'b0);
    tick();
    check("t2_ready_at7", 32'(in_ready), 32'd0);
    drive(1'b1, 1'b1, 32'h2000, 32'h2004, 2'd2, 1'b0);
    tick();
    check("t2_ready_reopen", 32'(in_ready), 32'd1);
    check("t2_head_pc", out_pc1, 32'h100c);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0);
    tick();

    // lone slot 2 lands at head
    do_reset();
    drive(1'b0, 1'b1, 32'h0, 32'h100, 2'd0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0);
    check("t3_valid1", 32'(out_valid1), 32'd1);
    check("t3_pc1", out_pc1, 32'h100);
    check("t3_valid2", 32'(out_valid2), 32'd0);
    tick();

    // wrap: move head/tail to 7, then enqueue across the boundary
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 32'h300 + 32'(i * 8), 32'h304 + 32'(i * 8), 2'd0, 1'b0);
      tick();
    end
    drive(1'b1, 1'b0, 32'h318, 32'h0, 2'd0, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 32'd0, 32'd0, (i == 3) ? 2'd1 : 2'd2, 1'b0);
      tick();
    end
    check("t4_empty", 32'(out_valid1), 32'd0);
    drive(1'b1, 1'b1, 32'h200, 32'h204, 2'd0, 1'b0);
    tick();
    check("t4_pc1", out_pc1, 32'h200);
    check("t4_pc2", out_pc2, 32'h204);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 2'd1, 1'b0);
    tick();
    check("t4_pc1_wrapped", out_pc1, 32'h204);

    // over-pop at count 1 clamps to empty
    drive(1'b0, 1'b0, 32'd0, 32'd0, 2'd2, 1'b0);
    tick();
    check("t5_valid1", 32'(out_valid1), 32'd0);
    check("t5_ready", 32'(in_ready), 32'd1);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 2'd3, 1'b0);
    tick();

    // flush beats a same-cycle enqueue and pop at count 5
    drive(1'b1, 1'b1, 32'h400, 32'h404, 2'd0, 1'b0);
    tick();
    tick();
    drive(1'b1, 1'b0, 32'h410, 32'h0, 2'd0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 32'h500, 32'h504, 2'd1, 1'b1);
    tick();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0);
    check("t6_valid1", 32'(out_valid1), 32'd0);
    check("t6_valid2", 32'(out_valid2), 32'd0);
    tick();
    drive(1'b1, 1'b1, 32'h600, 32'h604, 2'd0, 1'b0);
    tick();
    check("t6_after_pc1", out_pc1, 32'h600);

    // randomized traffic with a mid-run asynchronous reset
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) begin
        #2;
        do_reset();
      end
      drive(1'($urandom), 1'($urandom), $urandom, $urandom, 2'($urandom),
            ($urandom % 32) == 0);
      tick();
    end
    drive(1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0);
    check_model();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
